// File: rtl/swdev_pkg.sv
// Shared definitions for the switch/button peripheral: register word addresses,
// CTRL bit positions and the debounce FSM state type.
package swdev_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_MASK   = 2'd3;

    localparam int CTRL_IE  = 0;
    localparam int CTRL_CLR = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } db_state_e;

endpackage

// File: rtl/swdev_debounce.sv
// Input conditioning for the switch peripheral: optional 2-flop synchroniser
// (enabled by defining SWDEV_SYNC_EN), then a debounce FSM that commits a new
// stable value after DB_CYC consecutive equal samples. commit is high during
// the cycle whose rising edge loads the new stable value; changed holds the
// bits that will flip on that edge.
module swdev_debounce
    import swdev_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DB_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_raw,
    output logic [WIDTH-1:0] stable,
    output logic [WIDTH-1:0] changed,
    output logic             commit
);

    localparam int             CW       = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYC - 1);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] cand_q;
    logic [CW-1:0]    cnt_q;
    db_state_e        state_q;

`ifdef SWDEV_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Two-stage synchroniser for the asynchronous switch lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in_raw;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    // Lines arrive already synchronised to clk
    assign s = in_raw;
`endif

    // Debounce FSM: track a candidate value and commit it once it has held long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (s != stable_q) begin
                        cand_q  <= s;
                        cnt_q   <= '0;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (s == stable_q) begin
                        // Input bounced back to the committed value: drop the attempt
                        state_q <= IDLE;
                    end else if (s != cand_q) begin
                        cand_q <= s;
                        cnt_q  <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        stable_q <= cand_q;
                        state_q  <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign commit  = (state_q == SETTLE) && (s != stable_q) && (s == cand_q) && (cnt_q == CNT_LAST);
    assign changed = cand_q ^ stable_q;
    assign stable  = stable_q;

endmodule

// File: rtl/switch_irq_dev.sv
// Debounced parallel-input peripheral with a maskable change interrupt.
// Registers: 0 CTRL (IE, write-1 CLR), 1 DATA (ro), 2 STATUS (pending, ro),
// 3 MASK (rw). Define SWDEV_SYNC_EN to add a 2-flop input synchroniser.
module switch_irq_dev
    import swdev_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DB_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [31:0]      din,
    output logic [31:0]      dout,
    input  logic [WIDTH-1:0] in_raw,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] changed;
    logic             commit;

    logic             ie_q, ie_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             wr_ctrl, wr_mask;

    swdev_debounce #(
        .WIDTH  (WIDTH),
        .DB_CYC (DB_CYC)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .in_raw  (in_raw),
        .stable  (stable),
        .changed (changed),
        .commit  (commit)
    );

    assign wr_ctrl = we && (addr == ADDR_CTRL);
    assign wr_mask = we && (addr == ADDR_MASK);

    // Next-state for control, mask and pending; a masked commit beats a same-cycle clear
    always_comb begin
        ie_d      = ie_q;
        mask_d    = mask_q;
        pending_d = pending_q;
        if (wr_ctrl) begin
            ie_d = din[CTRL_IE];
            if (din[CTRL_CLR]) pending_d = 1'b0;
        end
        if (wr_mask) mask_d = din[WIDTH-1:0];
        if (commit && ((changed & mask_q) != '0)) pending_d = 1'b1;
    end

    // Register file state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_q      <= 1'b0;
            pending_q <= 1'b0;
            mask_q    <= '1;
        end else begin
            ie_q      <= ie_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
        end
    end

    // Side-effect-free read mux
    always_comb begin
        dout = '0;
        case (addr)
            ADDR_CTRL:   dout[CTRL_IE]      = ie_q;
            ADDR_DATA:   dout[WIDTH-1:0]    = stable;
            ADDR_STATUS: dout[0]            = pending_q;
            ADDR_MASK:   dout[WIDTH-1:0]    = mask_q;
            default:     dout               = '0;
        endcase
    end

    assign irq = pending_q & ie_q;

endmodule
